// File: rtl/route_dispatch_pkg.sv
// route_dispatch_pkg: shared item/direction widths, direction codes and direction validity check
package route_dispatch_pkg;
  localparam int SIZE = 8;
  localparam int BITS_DIR = 3;
  localparam int NPORTS = 5;
  localparam logic [BITS_DIR-1:0] DIR_N = 3'd0;
  localparam logic [BITS_DIR-1:0] DIR_S = 3'd1;
  localparam logic [BITS_DIR-1:0] DIR_E = 3'd2;
  localparam logic [BITS_DIR-1:0] DIR_W = 3'd3;
  localparam logic [BITS_DIR-1:0] DIR_L = 3'd4;
  function automatic logic dir_ok(input logic [BITS_DIR-1:0] d);
    return d <= DIR_L;
  endfunction
endpackage

// File: rtl/route_dispatch_if.sv
// route_dispatch_if: fifo, routing-table and per-port tx handshake bundle of the dispatch stage
interface route_dispatch_if;
  import route_dispatch_pkg::*;
  logic fifo_empty;
  logic [SIZE-1:0] fifo_data_out;
  logic fifo_read;
  logic [SIZE-1:0] table_addr;
  logic [BITS_DIR-1:0] table_data;
  logic [NPORTS-1:0] fifo_pop_req;
  logic [NPORTS-1:0] fifo_pop_ack;
  logic [NPORTS*SIZE-1:0] fifo_pop_data;
  logic route_err;
  modport master (
    output fifo_empty, fifo_data_out, table_data, fifo_pop_ack,
    input fifo_read, table_addr, fifo_pop_req, fifo_pop_data, route_err
  );
  modport slave (
    input fifo_empty, fifo_data_out, table_data, fifo_pop_ack,
    output fifo_read, table_addr, fifo_pop_req, fifo_pop_data, route_err
  );
endinterface

// File: rtl/route_dispatch_port_counter.sv
// route_dispatch_port_counter: CNT_W-bit wrapping delivery counter with enable
module route_dispatch_port_counter #(
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic [CNT_W-1:0] count
);
  // count one delivery per enabled cycle, wrapping naturally
  always_ff @(posedge clk or posedge reset)
    if (reset) count <= '0;
    else if (en) count <= count + 1'b1;
endmodule

// File: rtl/route_dispatch.sv
// route_dispatch: pops one fifo item, resolves its direction, delivers it over 4-phase req/ack; DISPATCH_STATS_EN adds per-port counters
module route_dispatch
  import route_dispatch_pkg::*;
#(
  parameter int id = -1,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic reset,
  route_dispatch_if.slave bus
`ifdef DISPATCH_STATS_EN
  , output logic [NPORTS*CNT_W-1:0] port_count
`endif
);
  localparam int DW = NPORTS * SIZE;
  typedef enum logic [1:0] {IDLE, LOOKUP, REQ, RTZ} state_t;
  state_t state;
  logic [SIZE-1:0] item;
  logic [BITS_DIR-1:0] dir;
  // id and CNT_W are identification/configuration only; referenced so every build elaborates them
  if (id < -1 && CNT_W < 1) begin : g_cfg
  end
  // pop only from a non-empty fifo while idle; suppressed during reset so all outputs read 0
  assign bus.fifo_read = !reset && state == IDLE && !bus.fifo_empty;
  // dispatch sequencer: IDLE pop -> LOOKUP steer/drop -> REQ until ack -> RTZ until ack release
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      item <= '0;
      dir <= '0;
      bus.table_addr <= '0;
      bus.fifo_pop_req <= '0;
      bus.fifo_pop_data <= '0;
      bus.route_err <= 1'b0;
    end else begin
      bus.route_err <= 1'b0;
      case (state)
        IDLE: if (!bus.fifo_empty) begin
          item <= bus.fifo_data_out;
          bus.table_addr <= bus.fifo_data_out;
          state <= LOOKUP;
        end
        LOOKUP: begin
          dir <= bus.table_data;
          if (dir_ok(bus.table_data)) begin
            bus.fifo_pop_req <= NPORTS'(1) << bus.table_data;
            bus.fifo_pop_data <= DW'(item) << (SIZE * bus.table_data);
            state <= REQ;
          end else begin
            bus.route_err <= 1'b1;
            state <= IDLE;
          end
        end
        REQ: if (bus.fifo_pop_ack[dir]) begin
          bus.fifo_pop_req <= '0;
          state <= RTZ;
        end
        RTZ: if (!bus.fifo_pop_ack[dir]) begin
          bus.fifo_pop_data <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
`ifdef DISPATCH_STATS_EN
  logic [NPORTS-1:0] done;
  assign done = (state == REQ && bus.fifo_pop_ack[dir]) ? bus.fifo_pop_req : '0;
  for (genvar i = 0; i < NPORTS; i++) begin : g_cnt
    route_dispatch_port_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk(clk),
      .reset(reset),
      .en(done[i]),
      .count(port_count[i*CNT_W +: CNT_W])
    );
  end
`endif
endmodule

// File: tb/tb_route_dispatch.sv
// tb_route_dispatch: directed checks of pop/lookup/steer/handshake, invalid-direction drop, stall, async reset
module tb_route_dispatch;
  import route_dispatch_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  route_dispatch_if bus();
`ifdef DISPATCH_STATS_EN
  logic [19:0] port_count;
`endif
  route_dispatch #(.id(3), .CNT_W(4)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
`ifdef DISPATCH_STATS_EN
    , .port_count(port_count)
`endif
  );
  int tests = 0;
  int fails = 0;
  logic [7:0] mem [0:63];
  logic [5:0] wp = '0;
  logic [5:0] rd = '0;
  logic [2:0] lut [0:255];
  logic auto_ack = 1'b1;
  logic [4:0] ack_man = '0;
  int bad_pop = 0;
  assign bus.fifo_empty = rd == wp;
  assign bus.fifo_data_out = mem[rd];
  assign bus.table_data = lut[bus.table_addr];
  // fifo pop model and tx transceivers answering one cycle after req
  always @(posedge clk) begin
    if (bus.fifo_read) begin
      if (rd == wp) bad_pop <= bad_pop + 1;
      else rd <= rd + 1'b1;
    end
    bus.fifo_pop_ack <= auto_ack ? bus.fifo_pop_req : ack_man;
  end
  logic [4:0] req_log [$];
  logic [39:0] data_log [$];
  logic [4:0] prev_req = '0;
  int err_cnt = 0;
  int hot_bad = 0;
  // log each new request with its data, count error pulses and one-hot violations
  always @(negedge clk) begin
    if (bus.fifo_pop_req != 0 && prev_req == 0) begin
      req_log.push_back(bus.fifo_pop_req);
      data_log.push_back(bus.fifo_pop_data);
    end
    prev_req = bus.fifo_pop_req;
    if (bus.route_err) err_cnt++;
    if (!$onehot0(bus.fifo_pop_req)) hot_bad++;
  end
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic push(input logic [7:0] d);
    @(negedge clk);
    mem[wp] = d;
    wp = wp + 1'b1;
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    for (int i = 0; i < 256; i++) lut[i] = 3'd7;
    lut[8'h2A] = 3'd2;
    lut[8'h01] = 3'd0;
    lut[8'h02] = 3'd4;
    lut[8'h03] = 3'd3;
    lut[8'h66] = 3'd1;
    lut[8'h77] = 3'd1;
    lut[8'h78] = 3'd0;
    lut[8'h99] = 3'd3;
    lut[8'hAB] = 3'd2;
    lut[8'h11] = 3'd2;
    cyc(3);
    check("rst_req", 64'(bus.fifo_pop_req), 64'h0);
    check("rst_read", 64'(bus.fifo_read), 64'h0);
    check("rst_data", 64'(bus.fifo_pop_data), 64'h0);
    check("rst_err", 64'(bus.route_err), 64'h0);
    check("rst_addr", 64'(bus.table_addr), 64'h0);
    reset = 1'b0;
    push(8'h2A);
    #1 check("t1_read_pulse", 64'(bus.fifo_read), 64'h1);
    cyc(1);
    check("t1_addr", 64'(bus.table_addr), 64'h2A);
    check("t1_read_low", 64'(bus.fifo_read), 64'h0);
    cyc(1);
    check("t1_req", 64'(bus.fifo_pop_req), 64'h04);
    check("t1_data", 64'(bus.fifo_pop_data), 64'h00002A0000);
    cyc(1);
    check("t1_req_hold", 64'(bus.fifo_pop_req), 64'h04);
    cyc(1);
    check("t1_req_fall", 64'(bus.fifo_pop_req), 64'h0);
    check("t1_data_held", 64'(bus.fifo_pop_data), 64'h00002A0000);
    cyc(2);
    check("t1_data_clr", 64'(bus.fifo_pop_data), 64'h0);
    check("t1_pops", 64'(rd), 64'd1);
    push(8'h01);
    push(8'h02);
    push(8'h03);
    cyc(40);
    check("t2_log_size", 64'(req_log.size()), 64'd4);
    check("t2_req0", 64'(req_log[1]), 64'h01);
    check("t2_req1", 64'(req_log[2]), 64'h10);
    check("t2_req2", 64'(req_log[3]), 64'h08);
    check("t2_data0", 64'(data_log[1]), 64'h0000000001);
    check("t2_data1", 64'(data_log[2]), 64'h0200000000);
    check("t2_data2", 64'(data_log[3]), 64'h0003000000);
    check("t2_pops", 64'(rd), 64'd4);
    push(8'h55);
    push(8'h66);
    cyc(20);
    check("t3_err_pulses", 64'(err_cnt), 64'd1);
    check("t3_log_size", 64'(req_log.size()), 64'd5);
    check("t3_req", 64'(req_log[4]), 64'h02);
    check("t3_data", 64'(data_log[4]), 64'h0000006600);
    auto_ack = 1'b0;
    push(8'h77);
    push(8'h78);
    cyc(5);
    check("t4_req_s", 64'(bus.fifo_pop_req), 64'h02);
    ack_man = 5'b00001;
    cyc(20);
    check("t4_stall_req", 64'(bus.fifo_pop_req), 64'h02);
    check("t4_stall_data", 64'(bus.fifo_pop_data), 64'h0000007700);
    check("t4_stall_pops", 64'(rd), 64'd7);
    ack_man = 5'b00010;
    cyc(3);
    check("t4_req_fall", 64'(bus.fifo_pop_req), 64'h0);
    check("t4_rtz_pops", 64'(rd), 64'd7);
    ack_man = 5'b00000;
    auto_ack = 1'b1;
    cyc(15);
    check("t4_next_req", 64'(req_log[req_log.size()-1]), 64'h01);
    check("t4_pops", 64'(rd), 64'd8);
    auto_ack = 1'b0;
    push(8'h99);
    cyc(3);
    check("t5_req_w", 64'(bus.fifo_pop_req), 64'h08);
    #2 reset = 1'b1;
    #1;
    check("t5_rst_req", 64'(bus.fifo_pop_req), 64'h0);
    check("t5_rst_data", 64'(bus.fifo_pop_data), 64'h0);
    check("t5_rst_read", 64'(bus.fifo_read), 64'h0);
    check("t5_rst_addr", 64'(bus.table_addr), 64'h0);
    cyc(1);
    reset = 1'b0;
    auto_ack = 1'b1;
    push(8'hAB);
    cyc(15);
    check("t5_next_req", 64'(req_log[req_log.size()-1]), 64'h04);
    check("t5_next_data", 64'(data_log[data_log.size()-1]), 64'h0000AB0000);
    check("t5_pops", 64'(rd), 64'd10);
`ifdef DISPATCH_STATS_EN
    for (int i = 0; i < 16; i++) push(8'h11);
    cyc(160);
    check("t6_cnt_e", 64'(port_count[11:8]), 64'd1);
    check("t6_cnt_other", 64'({port_count[19:12], port_count[7:0]}), 64'h0);
    check("t6_pops", 64'(rd), 64'd26);
`endif
    check("no_empty_pop", 64'(bad_pop), 64'd0);
    check("req_onehot", 64'(hot_bad), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
